sound_scheduler: RTL and testbench
==================================

SOUND_SCHEDULER -- requirements
Module: sound_scheduler

Interface
REQ-001 SHALL have port Clk, input, 1, single system clock; all logic rising-edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port enable, input, 1, playback enable; low means mute and abort.
REQ-004 SHALL have port sample_div, input, 16, clock cycles per sample tick; 0 is treated as 1.
REQ-005 SHALL have ports sfx_word (input, 32), sfx_valid (input, 1) and sfx_ready (output, 1), the effects requester.
REQ-006 SHALL have ports bgm_word (input, 32), bgm_valid (input, 1) and bgm_ready (output, 1), the music requester.
REQ-007 SHALL have port out_sound, output, 5, current 5-bit sample slice.
REQ-008 SHALL have port out_strobe, output, 1, one-cycle pulse when out_sound updates.
REQ-009 SHALL have port active_src, output, 1, source of the word in play; 1 = sfx, 0 = bgm.
REQ-010 SHALL have port underrun, output, 1, one-cycle pulse when a word is needed and neither requester is valid.

Function
REQ-011 Prescaler counts 0..max(sample_div,1)-1; tick asserts in the cycle the count equals the terminal value; count wraps to 0.
REQ-012 Prescaler runs only while enable=1; held at 0 while enable=0.
REQ-013 States: IDLE, PLAY; slot counter 0..5 is valid in PLAY.
REQ-014 Load cycle: a tick while in IDLE, or a tick while in PLAY with slot=5.
REQ-015 Grant in a load cycle: sfx if sfx_valid, else bgm if bgm_valid, else none (subject to REQ-030).
REQ-016 x_ready is combinational; high only in a load cycle for the granted source; the word is accepted in that cycle; the other ready stays 0.
REQ-017 On accept, the word is latched; the FSM goes to or stays in PLAY; slot becomes 0; out_sound is driven with word[29:25] from the next cycle.
REQ-018 Each later tick advances slot k to k+1 and emits its slice: 1=[24:20], 2=[19:15], 3=[14:10], 4=[9:5], 5=[4:0]; bits [31:30] are ignored.
REQ-019 out_strobe is high in the cycle after every tick that emits a slice; latency is one cycle from tick.
REQ-020 Gapless playback: a load cycle with a grant emits slot 0 of the new word on that tick, with no idle sample between words.
REQ-021 Load cycle with no grant: underrun pulses in the next cycle; out_sound becomes 0; out_strobe pulses; FSM goes to IDLE.
REQ-022 enable falling mid-word: in the next cycle the FSM goes to IDLE, slot becomes 0, out_sound becomes 0, out_strobe stays 0, the latched word is dropped, and both readies are 0.
REQ-023 valid deasserted in a non-load cycle has no effect; words are never accepted outside load cycles.
REQ-024 sample_div changes take effect on the next prescaler wrap.

Reset
REQ-025 reset_n low SHALL asynchronously force state=IDLE, slot=0, prescaler=0, out_sound=0, out_strobe=0, active_src=0, underrun=0, fairness counter=0.
REQ-026 Readies SHALL be 0 while reset_n is low.
REQ-027 Reset mid-word SHALL discard the word; the first tick after release behaves as IDLE.
REQ-028 Release is synchronous to Clk; the first tick occurs sample_div cycles after release when enable=1.

Configuration
REQ-029 Macro SOUND_SCHED_FAIR_EN SHALL select the arbitration fairness feature.
REQ-030 Defined: a 2-bit counter counts consecutive sfx grants made while bgm_valid=1; when it reaches 3, the next contended grant goes to bgm and the counter clears; the counter also clears on any bgm grant.
REQ-031 Undefined: strict sfx priority; bgm can starve; no counter is implemented.

Verification
REQ-032 sample_div=4, bgm_valid=1, bgm_word=0x3E0F83E0 -> bgm_ready pulses on the first tick; out_sound sequence 31,0,31,0,31,0, one every 4 cycles.
REQ-033 sfx and bgm both valid continuously, macro undefined -> only sfx_ready pulses for 10 words; with the macro defined -> grant order sfx,sfx,sfx,bgm repeating.
REQ-034 Single bgm word, then valid=0 -> 6 slices are emitted, then on the 7th tick underrun=1, out_sound=0, FSM=IDLE.
REQ-035 enable dropped after slot 2 -> next cycle out_sound=0, no further strobes; on re-enable a fresh word starts at slot 0.
REQ-036 reset_n asserted mid-slot 3 -> all outputs are 0 immediately without a clock edge; after release, slot 0 of a new word follows the first tick.
REQ-037 sample_div=0 -> a tick every cycle; out_strobe is continuously high during gapless playback.

Source files
------------

// File: rtl/sound_scheduler.sv
// Two-source sample-slice scheduler: prescaled sample ticks play six 5-bit slices per 32-bit word.
// Define SOUND_SCHED_FAIR_EN to enable bgm fairness arbitration (default: strict sfx priority).
module sound_scheduler (
    input  logic        Clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [15:0] sample_div,
    input  logic [31:0] sfx_word,
    input  logic        sfx_valid,
    output logic        sfx_ready,
    input  logic [31:0] bgm_word,
    input  logic        bgm_valid,
    output logic        bgm_ready,
    output logic [4:0]  out_sound,
    output logic        out_strobe,
    output logic        active_src,
    output logic        underrun
);
    // state | meaning
    // IDLE  | no word held; the next tick is a load cycle
    // PLAY  | word held; slot_q is the slice most recently emitted (0..5)

    typedef enum logic {ST_IDLE = 1'b0, ST_PLAY = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [2:0]  slot_q, slot_d;
    logic [15:0] pre_cnt_q, pre_cnt_d;
    logic [15:0] pre_term_q, pre_term_d;
    logic [29:0] word_q, word_d;
    logic [4:0]  out_sound_q, out_sound_d;
    logic        out_strobe_q, out_strobe_d;
    logic        active_src_q, active_src_d;
    logic        underrun_q, underrun_d;

    logic [15:0] live_term;
    logic [15:0] cur_term;
    logic        tick;
    logic        load;
    logic        grant_sfx;
    logic        grant_bgm;
    logic        unused_hi_bits;

    // Bits [31:30] of both request words carry no audio.
    assign unused_hi_bits = ^{sfx_word[31:30], bgm_word[31:30]};

    function automatic logic [4:0] slice_of(input logic [29:0] w, input logic [2:0] k);
        logic [4:0] s;
        case (k)
            3'd0:    s = w[29:25];
            3'd1:    s = w[24:20];
            3'd2:    s = w[19:15];
            3'd3:    s = w[14:10];
            3'd4:    s = w[9:5];
            3'd5:    s = w[4:0];
            default: s = 5'd0;
        endcase
        return s;
    endfunction

    // Terminal value is sampled at count 0 and held, so divider changes land on a wrap.
    always_comb begin
        live_term = (sample_div == 16'd0) ? 16'd0 : (sample_div - 16'd1);
        cur_term  = (pre_cnt_q == 16'd0) ? live_term : pre_term_q;
        tick      = enable && (pre_cnt_q == cur_term);
        load      = tick && ((state_q == ST_IDLE) || (slot_q == 3'd5));
    end

`ifdef SOUND_SCHED_FAIR_EN
    logic [1:0] fair_q, fair_d;

    always_comb begin
        grant_sfx = sfx_valid && !(bgm_valid && (fair_q == 2'd3));
        grant_bgm = bgm_valid && !grant_sfx;
        fair_d    = fair_q;
        if (load && grant_bgm) begin
            fair_d = 2'd0;
        end else if (load && grant_sfx && bgm_valid) begin
            fair_d = fair_q + 2'd1;
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            fair_q <= 2'd0;
        end else begin
            fair_q <= fair_d;
        end
    end
`else
    always_comb begin
        grant_sfx = sfx_valid;
        grant_bgm = bgm_valid && !sfx_valid;
    end
`endif

    assign sfx_ready = reset_n && load && grant_sfx;
    assign bgm_ready = reset_n && load && grant_bgm;

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        pre_cnt_d    = pre_cnt_q;
        pre_term_d   = pre_term_q;
        word_d       = word_q;
        out_sound_d  = out_sound_q;
        out_strobe_d = 1'b0;
        active_src_d = active_src_q;
        underrun_d   = 1'b0;

        if (!enable) begin
            pre_cnt_d    = 16'd0;
            pre_term_d   = live_term;
            state_d      = ST_IDLE;
            slot_d       = 3'd0;
            word_d       = 30'd0;
            out_sound_d  = 5'd0;
            active_src_d = 1'b0;
        end else begin
            pre_term_d = cur_term;
            pre_cnt_d  = tick ? 16'd0 : (pre_cnt_q + 16'd1);

            if (load) begin
                out_strobe_d = 1'b1;
                slot_d       = 3'd0;
                if (grant_sfx || grant_bgm) begin
                    word_d       = grant_sfx ? sfx_word[29:0] : bgm_word[29:0];
                    state_d      = ST_PLAY;
                    out_sound_d  = grant_sfx ? sfx_word[29:25] : bgm_word[29:25];
                    active_src_d = grant_sfx;
                end else begin
                    word_d       = 30'd0;
                    state_d      = ST_IDLE;
                    out_sound_d  = 5'd0;
                    active_src_d = 1'b0;
                    underrun_d   = 1'b1;
                end
            end else if (tick) begin
                slot_d       = slot_q + 3'd1;
                out_sound_d  = slice_of(word_q, slot_q + 3'd1);
                out_strobe_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            slot_q       <= 3'd0;
            pre_cnt_q    <= 16'd0;
            pre_term_q   <= 16'd0;
            word_q       <= 30'd0;
            out_sound_q  <= 5'd0;
            out_strobe_q <= 1'b0;
            active_src_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            pre_cnt_q    <= pre_cnt_d;
            pre_term_q   <= pre_term_d;
            word_q       <= word_d;
            out_sound_q  <= out_sound_d;
            out_strobe_q <= out_strobe_d;
            active_src_q <= active_src_d;
            underrun_q   <= underrun_d;
        end
    end

    assign out_sound  = out_sound_q;
    assign out_strobe = out_strobe_q;
    assign active_src = active_src_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_sound_scheduler.sv
// Bench for sound_scheduler: queue-based reference model checked every cycle plus directed literal checks.
module tb_sound_scheduler;
`ifdef SOUND_SCHED_FAIR_EN
    localparam bit FAIR_ON = 1'b1;
`else
    localparam bit FAIR_ON = 1'b0;
`endif

    logic        Clk;
    logic        reset_n;
    logic        enable;
    logic [15:0] sample_div;
    logic [31:0] sfx_word;
    logic        sfx_valid;
    logic        sfx_ready;
    logic [31:0] bgm_word;
    logic        bgm_valid;
    logic        bgm_ready;
    logic [4:0]  out_sound;
    logic        out_strobe;
    logic        active_src;
    logic        underrun;

    sound_scheduler dut (
        .Clk        (Clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .sample_div (sample_div),
        .sfx_word   (sfx_word),
        .sfx_valid  (sfx_valid),
        .sfx_ready  (sfx_ready),
        .bgm_word   (bgm_word),
        .bgm_valid  (bgm_valid),
        .bgm_ready  (bgm_ready),
        .out_sound  (out_sound),
        .out_strobe (out_strobe),
        .active_src (active_src),
        .underrun   (underrun)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycles elapsed in the sample period, and a queue of slices still to play.
    int          m_phase = 0;
    int          m_period = 1;
    int          m_fair = 0;
    int          m_q[$];
    int          e_sound = 0;
    bit          e_strobe = 1'b0;
    bit          e_under = 1'b0;
    bit          e_src = 1'b0;
    int          m_per;
    int          m_g;
    logic [31:0] m_w;

    function automatic int grant_of(input bit sv, input bit bv, input int fair);
        if (sv) begin
            if (FAIR_ON && bv && fair == 3) return 2;
            return 1;
        end
        if (bv) return 2;
        return 0;
    endfunction

    function automatic int cur_period();
        if (m_phase == 0) return (sample_div == 16'd0) ? 1 : int'(sample_div);
        return m_period;
    endfunction

    always @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = 0; m_period = 1; m_fair = 0; m_q.delete();
            e_sound = 0; e_strobe = 0; e_under = 0; e_src = 0;
        end else if (!enable) begin
            m_phase = 0; m_q.delete();
            e_sound = 0; e_strobe = 0; e_under = 0; e_src = 0;
        end else begin
            m_per = cur_period();
            e_strobe = 0;
            e_under = 0;
            if (m_phase == m_per - 1) begin
                m_phase = 0;
                e_strobe = 1;
                if (m_q.size() == 0) begin
                    m_g = grant_of(sfx_valid, bgm_valid, m_fair);
                    if (m_g == 0) begin
                        e_under = 1; e_sound = 0; e_src = 0;
                    end else begin
                        m_w = (m_g == 1) ? sfx_word : bgm_word;
                        for (int i = 0; i < 6; i++) m_q.push_back(int'((m_w >> (25 - 5 * i)) & 32'h1F));
                        e_src = (m_g == 1);
                        if (m_g == 2) m_fair = 0;
                        else if (bgm_valid) m_fair = m_fair + 1;
                    end
                end
                if (m_q.size() != 0) e_sound = m_q.pop_front();
            end else begin
                m_phase = m_phase + 1;
            end
            m_period = m_per;
        end
    end

    bit c_ld;
    int c_g;
    always @(negedge Clk) begin
        if (cmp_en) begin
            c_ld = reset_n && enable && (m_phase == cur_period() - 1) && (m_q.size() == 0);
            c_g = grant_of(sfx_valid, bgm_valid, m_fair);
            chk("sfx_ready", int'(sfx_ready), int'(c_ld && c_g == 1));
            chk("bgm_ready", int'(bgm_ready), int'(c_ld && c_g == 2));
            chk("out_sound", int'(out_sound), e_sound);
            chk("out_strobe", int'(out_strobe), int'(e_strobe));
            chk("underrun", int'(underrun), int'(e_under));
            chk("active_src", int'(active_src), int'(e_src));
        end
    end

    int cycles;
    bit seen;
    int strobes;
    int sl[$];
    bit und;
    int und_sound;
    int gr[10];
    int n_gr;
    bit seen_strobe;
    int low_cnt;
    int exp_sl[6] = '{31, 0, 31, 0, 31, 0};

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    task automatic wait_ready(input bit want_sfx, output bit got, output int n);
        got = 0;
        n = 0;
        while (!got && n < 60) begin
            @(negedge Clk);
            n++;
            if (want_sfx ? sfx_ready : bgm_ready) got = 1;
        end
    endtask

    task automatic wait_strobes(input int count, output int got_n);
        int n;
        got_n = 0;
        n = 0;
        while (got_n < count && n < 100) begin
            @(negedge Clk);
            n++;
            if (out_strobe) got_n++;
        end
    endtask

    initial begin
        reset_n = 1; enable = 0; sample_div = 16'd4;
        sfx_word = 0; sfx_valid = 0; bgm_word = 0; bgm_valid = 0;
        #1 reset_n = 0;
        #1 cmp_en = 1;
        repeat (3) @(negedge Clk);
        chk("reset_out_sound", int'(out_sound), 0);
        chk("reset_out_strobe", int'(out_strobe), 0);
        chk("reset_underrun", int'(underrun), 0);
        chk("reset_active_src", int'(active_src), 0);

        // Single bgm word at divider 4, then the source goes quiet.
        step();
        reset_n = 1; enable = 1; bgm_word = 32'h3E0F_83E0; bgm_valid = 1;
        wait_ready(1'b0, seen, cycles);
        chk("first_bgm_ready_seen", int'(seen), 1);
        chk("first_tick_cycle", cycles, 4);
        step();
        bgm_valid = 0;
        und = 0; und_sound = -1; cycles = 0;
        while (!und && cycles < 60) begin
            @(negedge Clk);
            cycles++;
            if (out_strobe) begin
                if (underrun) begin
                    und = 1;
                    und_sound = int'(out_sound);
                end else begin
                    sl.push_back(int'(out_sound));
                end
            end
        end
        chk("bgm_slice_count", sl.size(), 6);
        for (int i = 0; i < 6; i++) chk("bgm_slice_value", (i < sl.size()) ? sl[i] : -1, exp_sl[i]);
        chk("underrun_seen", int'(und), 1);
        chk("underrun_sound", und_sound, 0);
        step();
        enable = 0;

        // Both sources valid continuously at divider 0.
        step();
        sample_div = 16'd0; sfx_word = 32'h1234_5678; bgm_word = 32'h0ABC_DEF0;
        sfx_valid = 1; bgm_valid = 1; enable = 1;
        n_gr = 0; cycles = 0; seen_strobe = 0; low_cnt = 0;
        while (n_gr < 10 && cycles < 200) begin
            @(negedge Clk);
            cycles++;
            if (sfx_ready) begin gr[n_gr] = 1; n_gr++; end
            else if (bgm_ready) begin gr[n_gr] = 2; n_gr++; end
            if (out_strobe) seen_strobe = 1;
            else if (seen_strobe) low_cnt++;
        end
        chk("contend_grant_count", n_gr, 10);
        for (int i = 0; i < 10; i++) chk("contend_grant_order", gr[i], (FAIR_ON && (i % 4) == 3) ? 2 : 1);
        chk("gapless_strobe_low_cycles", low_cnt, 0);
        step();
        enable = 0; sfx_valid = 0; bgm_valid = 0;

        // Enable dropped after slot 2, then a fresh word.
        step();
        sample_div = 16'd3; sfx_word = 32'h1557_3CA5; sfx_valid = 1; enable = 1;
        wait_ready(1'b1, seen, cycles);
        chk("abort_sfx_ready_seen", int'(seen), 1);
        step();
        sfx_valid = 0;
        wait_strobes(3, strobes);
        chk("abort_slices_before_drop", strobes, 3);
        chk("abort_slot2_value", int'(out_sound), 14);
        step();
        enable = 0;
        @(negedge Clk);
        @(negedge Clk);
        chk("abort_out_sound", int'(out_sound), 0);
        chk("abort_out_strobe", int'(out_strobe), 0);
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (out_strobe) strobes++;
        end
        chk("abort_no_strobes", strobes, 0);
        step();
        sfx_word = 32'h2AAA_AAAA; sfx_valid = 1; enable = 1;
        wait_ready(1'b1, seen, cycles);
        chk("reenable_ready_seen", int'(seen), 1);
        step();
        sfx_valid = 0;
        @(negedge Clk);
        chk("reenable_slot0", int'(out_sound), 21);
        chk("reenable_strobe", int'(out_strobe), 1);
        chk("reenable_src", int'(active_src), 1);

        // Asynchronous reset in the middle of slot 3.
        wait_strobes(3, strobes);
        chk("prereset_slices", strobes, 3);
        chk("prereset_slot3_value", int'(out_sound), 10);
        step();
        reset_n = 0; sample_div = 16'd0; sfx_word = 32'h0C63_18C6; sfx_valid = 1;
        #1;
        chk("async_reset_out_sound", int'(out_sound), 0);
        chk("async_reset_active_src", int'(active_src), 0);
        chk("async_reset_strobe", int'(out_strobe), 0);
        chk("async_reset_sfx_ready", int'(sfx_ready), 0);
        step();
        reset_n = 1;
        wait_ready(1'b1, seen, cycles);
        chk("postreset_ready_cycle", cycles, 1);
        step();
        sfx_valid = 0;
        @(negedge Clk);
        chk("postreset_slot0", int'(out_sound), 6);

        // Divider change mid-word with both sources contending, then bgm alone.
        step();
        sample_div = 16'd5; sfx_word = 32'h3F00_FF0F; bgm_word = 32'h05A5_A5A5;
        sfx_valid = 1; bgm_valid = 1;
        repeat (33) @(negedge Clk);
        step();
        sample_div = 16'd2;
        repeat (60) @(negedge Clk);
        step();
        sfx_valid = 0;
        repeat (40) @(negedge Clk);

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
